// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared defaults and scheduler state encoding for the music player
package music_pkg;

    localparam int SONG_W_DEFAULT = 4;
    localparam int DEPTH_DEFAULT  = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        PLAYING = 3'd2,
        PAUSED  = 3'd3,
        ADVANCE = 3'd4
    } sched_state_t;

endpackage

// File: rtl/song_fifo.sv
// rtl/song_fifo.sv - single-write-port song queue with occupancy count
module song_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage is not reset; only pointers and count define valid contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/playlist_scheduler.sv
// rtl/playlist_scheduler.sv - queues keypad songs and sequences play/pause/skip/repeat
module playlist_scheduler
    import music_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int SONG_W = SONG_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SONG_W-1:0]        song_input,
    input  logic                     song_valid,
    input  logic                     play_button,
    input  logic                     next_button,
    input  logic                     repeat_mode,
    input  logic                     song_done,
    output logic                     play,
    output logic                     reset_player,
    output logic [SONG_W-1:0]        song,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     queue_empty,
    output logic                     queue_full,
    output logic                     dropped
);
    sched_state_t      state;
    logic              push;
    logic              pop;
    logic              drop;
    logic              repeat_push;
    logic              can_push;
    logic [SONG_W-1:0] push_data;
    logic [SONG_W-1:0] head;

    song_fifo #(
        .DEPTH (DEPTH),
        .W     (SONG_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (queue_count),
        .empty     (queue_empty),
        .full      (queue_full)
    );

    assign pop         = (state == LOAD);
    assign repeat_push = (state == ADVANCE) && repeat_mode;
    assign can_push    = !queue_full || pop;

    // One write port: the repeat re-append owns it in ADVANCE, so a keypad entry then is lost.
    always_comb begin
        push      = 1'b0;
        push_data = song_input;
        drop      = 1'b0;
        if (repeat_push) begin
            push_data = song;
            push      = can_push;
            drop      = !can_push || song_valid;
        end else if (song_valid) begin
            push = can_push;
            drop = !can_push;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            song         <= '0;
            play         <= 1'b0;
            reset_player <= 1'b0;
            dropped      <= 1'b0;
        end else begin
            reset_player <= 1'b0;
            dropped      <= drop;
            case (state)
                IDLE: begin
                    play <= 1'b0;
                    if (!queue_empty) begin
                        state        <= LOAD;
                        reset_player <= 1'b1;
                    end
                end
                LOAD: begin
                    song  <= head;
                    play  <= 1'b1;
                    state <= PLAYING;
                end
                PLAYING: begin
                    if (next_button || song_done) begin
                        state        <= ADVANCE;
                        play         <= 1'b0;
                        reset_player <= 1'b1;
                    end else if (play_button) begin
                        state <= PAUSED;
                        play  <= 1'b0;
                    end
                end
                PAUSED: begin
                    if (next_button) begin
                        state        <= ADVANCE;
                        reset_player <= 1'b1;
                    end else if (play_button) begin
                        state <= PLAYING;
                        play  <= 1'b1;
                    end
                end
                ADVANCE: begin
                    play  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    play  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_playlist_scheduler.sv
// tb/tb_playlist_scheduler.sv - directed self-checking bench for playlist_scheduler
module tb_playlist_scheduler;

    localparam int DEPTH  = 8;
    localparam int SONG_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [SONG_W-1:0] song_input;
    logic              song_valid;
    logic              play_button;
    logic              next_button;
    logic              repeat_mode;
    logic              song_done;
    logic              play;
    logic              reset_player;
    logic [SONG_W-1:0] song;
    logic [3:0]        queue_count;
    logic              queue_empty;
    logic              queue_full;
    logic              dropped;

    int checks = 0;
    int errors = 0;

    playlist_scheduler #(
        .DEPTH  (DEPTH),
        .SONG_W (SONG_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .song_input   (song_input),
        .song_valid   (song_valid),
        .play_button  (play_button),
        .next_button  (next_button),
        .repeat_mode  (repeat_mode),
        .song_done    (song_done),
        .play         (play),
        .reset_player (reset_player),
        .song         (song),
        .queue_count  (queue_count),
        .queue_empty  (queue_empty),
        .queue_full   (queue_full),
        .dropped      (dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one full cycle; inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        song_valid  = 1'b0;
        play_button = 1'b0;
        next_button = 1'b0;
        song_done   = 1'b0;
    endtask

    task automatic enqueue(input logic [SONG_W-1:0] s);
        song_input = s;
        song_valid = 1'b1;
        step();
        song_valid = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        song_input  = '0;
        repeat_mode = 1'b0;
        clear_inputs();
        step();
        step();
        reset = 1'b0;

        check("rst_play", play, 0);
        check("rst_reset_player", reset_player, 0);
        check("rst_song", song, 0);
        check("rst_count", queue_count, 0);
        check("rst_empty", queue_empty, 1);
        check("rst_full", queue_full, 0);
        check("rst_dropped", dropped, 0);

        // Enqueue 3 then 5: LOAD two cycles after the first strobe.
        song_input = 4'd3; song_valid = 1'b1;
        step();
        check("enq_count1", queue_count, 1);
        song_input = 4'd5;
        step();
        song_valid = 1'b0;
        check("load_pulse", reset_player, 1);
        check("load_play", play, 0);
        step();
        check("first_song", song, 3);
        check("first_play", play, 1);
        check("first_rp_low", reset_player, 0);
        check("first_count", queue_count, 1);

        // song_done -> ADVANCE, IDLE, LOAD, next song.
        song_done = 1'b1;
        step();
        song_done = 1'b0;
        check("adv_play", play, 0);
        check("adv_rp", reset_player, 1);
        step();
        check("idle_rp", reset_player, 0);
        check("idle_play", play, 0);
        step();
        check("load2_rp", reset_player, 1);
        step();
        check("second_song", song, 5);
        check("second_play", play, 1);
        check("second_count", queue_count, 0);
        song_done = 1'b1;
        step();
        song_done = 1'b0;
        step();
        step();
        check("drain_play", play, 0);
        check("drain_rp", reset_player, 0);
        check("drain_empty", queue_empty, 1);

        // Start song 7, then pause it.
        enqueue(4'd7);
        step();
        step();
        check("s7_song", song, 7);
        check("s7_play", play, 1);
        play_button = 1'b1;
        step();
        play_button = 1'b0;
        check("pause_play", play, 0);
        song_done = 1'b1;
        step();
        song_done = 1'b0;
        check("paused_done_ignored_play", play, 0);
        check("paused_done_ignored_rp", reset_player, 0);

        // Fill the queue while paused; ninth entry is dropped.
        for (int i = 1; i <= DEPTH; i++) begin
            enqueue(SONG_W'(i));
        end
        check("full_count", queue_count, 8);
        check("full_flag", queue_full, 1);
        check("full_no_drop", dropped, 0);
        enqueue(4'd9);
        check("ninth_dropped", dropped, 1);
        check("ninth_count", queue_count, 8);
        step();
        check("drop_one_cycle", dropped, 0);

        play_button = 1'b1;
        step();
        play_button = 1'b0;
        check("resume_play", play, 1);
        check("resume_song", song, 7);

        // play_button and next_button together: skip wins.
        play_button = 1'b1; next_button = 1'b1;
        step();
        clear_inputs();
        check("skip_play", play, 0);
        check("skip_rp", reset_player, 1);
        step();
        step();
        check("full_load_rp", reset_player, 1);
        // Keypad push during LOAD on a full queue: push and pop both happen.
        song_input = 4'd12; song_valid = 1'b1;
        step();
        song_valid = 1'b0;
        check("pushpop_song", song, 1);
        check("pushpop_count", queue_count, 8);
        check("pushpop_no_drop", dropped, 0);

        // Reset mid-song with a loaded queue.
        reset = 1'b1;
        step();
        check("midrst_count", queue_count, 0);
        check("midrst_song", song, 0);
        check("midrst_play", play, 0);
        check("midrst_rp", reset_player, 0);
        check("midrst_empty", queue_empty, 1);
        reset = 1'b0;

        // Repeat mode with queue {1,2}: order 1,2,1.
        repeat_mode = 1'b1;
        song_input = 4'd1; song_valid = 1'b1;
        step();
        song_input = 4'd2;
        step();
        song_valid = 1'b0;
        step();
        check("rep_song1", song, 1);
        check("rep_count1", queue_count, 1);
        song_done = 1'b1;
        step();
        song_done = 1'b0;
        step();
        check("rep_requeue_count", queue_count, 2);
        step();
        step();
        check("rep_song2", song, 2);
        check("rep_count2", queue_count, 1);
        song_done = 1'b1;
        step();
        song_done = 1'b0;
        // Keypad entry in ADVANCE collides with the repeat push and is lost.
        song_input = 4'd9; song_valid = 1'b1;
        step();
        song_valid = 1'b0;
        check("rep_collide_drop", dropped, 1);
        check("rep_collide_count", queue_count, 2);
        step();
        step();
        check("rep_song3", song, 1);
        check("rep_count3", queue_count, 1);
        check("rep_play3", play, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
